// File: rtl/ldpc_mem_pkg.sv
// Shared constants for the LDPC message-memory subsystem: SRAM geometry and
// the requester index encodings used by the port arbiters.
package ldpc_mem_pkg;

    localparam int MSG_AW = 8;
    localparam int MSG_DW = 8;

    // Writer indices on SRAM port B
    localparam logic W_IDX_LDR = 1'b0;   // channel-LLR loader
    localparam logic W_IDX_CNU = 1'b1;   // check-node writeback

    // Reader indices on SRAM port A (also the value returned on rd_tag)
    localparam logic R_IDX_VNU = 1'b0;   // variable-node update
    localparam logic R_IDX_HD  = 1'b1;   // output hard-decision unit

endpackage

// File: rtl/ldpc_sram_arbiter_if.sv
// Requester-side bus of the message SRAM arbiter: two writers, two readers
// and the shared tagged read-return path.
interface ldpc_sram_arbiter_if
    import ldpc_mem_pkg::*;
#(
    parameter int AW = MSG_AW,
    parameter int DW = MSG_DW
);
    logic          w0_req;
    logic          w1_req;
    logic [AW-1:0] w0_addr;
    logic [AW-1:0] w1_addr;
    logic [DW-1:0] w0_data;
    logic [DW-1:0] w1_data;
    logic          w0_gnt;
    logic          w1_gnt;

    logic          r0_req;
    logic          r1_req;
    logic [AW-1:0] r0_addr;
    logic [AW-1:0] r1_addr;
    logic          r0_gnt;
    logic          r1_gnt;

    logic          rd_vld;
    logic          rd_tag;
    logic [DW-1:0] rd_data;

    // Requesters drive requests and sample grants / read returns
    modport master (
        output w0_req, w1_req, w0_addr, w1_addr, w0_data, w1_data,
        output r0_req, r1_req, r0_addr, r1_addr,
        input  w0_gnt, w1_gnt, r0_gnt, r1_gnt,
        input  rd_vld, rd_tag, rd_data
    );

    // The arbiter consumes requests and produces grants / read returns
    modport slave (
        input  w0_req, w1_req, w0_addr, w1_addr, w0_data, w1_data,
        input  r0_req, r1_req, r0_addr, r1_addr,
        output w0_gnt, w1_gnt, r0_gnt, r1_gnt,
        output rd_vld, rd_tag, rd_data
    );

endinterface

// File: rtl/ldpc_rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester always wins; when both
// request, the pointer picks the winner and then flips to the loser, so
// continuous contention alternates strictly. Grants are forced low in reset.
module ldpc_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_reg;
    logic ptr_next;

    // A requester wins if it is alone or the pointer favours it
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        assign gnt[gi] = rst_n & req[gi] & (~req[1-gi] | (ptr_reg == 1'(gi)));
    end

    // Pointer moves to the complement of whoever was just granted
    always_comb begin
        ptr_next = ptr_reg;
        if (gnt[0]) begin
            ptr_next = 1'b1;
        end else if (gnt[1]) begin
            ptr_next = 1'b0;
        end
    end

    // Pointer register, favours index 0 out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/ldpc_sram_arbiter.sv
// Shares one two-port message SRAM between two writers (port B) and two
// readers (port A). Each port has its own round-robin arbiter; reads return
// one cycle after grant with a requester tag, and a read colliding with a
// same-cycle write to the same address can optionally see the new data.
module ldpc_sram_arbiter
    import ldpc_mem_pkg::*;
#(
    parameter int AW     = MSG_AW,
    parameter int DW     = MSG_DW,
    parameter bit FWD_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    ldpc_sram_arbiter_if.slave  bus,
    output logic [AW-1:0]       sram_addra,
    output logic                sram_ena,
    input  logic [DW-1:0]       sram_douta,
    output logic [AW-1:0]       sram_addrb,
    output logic [DW-1:0]       sram_dinb,
    output logic                sram_enb,
    output logic                sram_web
);

    logic [1:0]    wr_req;
    logic [1:0]    wr_gnt;
    logic [1:0]    rd_req;
    logic [1:0]    rd_gnt;
    logic          rd_sel;
    logic          collide;

    logic          rd_vld_reg;
    logic          rd_tag_reg;
    logic          fwd_reg;
    logic [DW-1:0] fwd_data_reg;

    assign wr_req[W_IDX_LDR] = bus.w0_req;
    assign wr_req[W_IDX_CNU] = bus.w1_req;
    assign rd_req[R_IDX_VNU] = bus.r0_req;
    assign rd_req[R_IDX_HD]  = bus.r1_req;

    ldpc_rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .gnt   (wr_gnt)
    );

    ldpc_rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    assign bus.w0_gnt = wr_gnt[W_IDX_LDR];
    assign bus.w1_gnt = wr_gnt[W_IDX_CNU];
    assign bus.r0_gnt = rd_gnt[R_IDX_VNU];
    assign bus.r1_gnt = rd_gnt[R_IDX_HD];

    // Drive SRAM ports from the granted requester; idle ports park at zero
    always_comb begin
        sram_enb   = 1'b1;
        sram_web   = 1'b0;
        sram_addrb = '0;
        sram_dinb  = '0;
        if (wr_gnt[W_IDX_LDR]) begin
            sram_enb   = 1'b0;
            sram_web   = 1'b1;
            sram_addrb = bus.w0_addr;
            sram_dinb  = bus.w0_data;
        end else if (wr_gnt[W_IDX_CNU]) begin
            sram_enb   = 1'b0;
            sram_web   = 1'b1;
            sram_addrb = bus.w1_addr;
            sram_dinb  = bus.w1_data;
        end

        sram_ena   = 1'b1;
        sram_addra = '0;
        rd_sel     = R_IDX_VNU;
        if (rd_gnt[R_IDX_VNU]) begin
            sram_ena   = 1'b0;
            sram_addra = bus.r0_addr;
            rd_sel     = R_IDX_VNU;
        end else if (rd_gnt[R_IDX_HD]) begin
            sram_ena   = 1'b0;
            sram_addra = bus.r1_addr;
            rd_sel     = R_IDX_HD;
        end
    end

    // The SRAM returns old contents when both ports hit one address together
    assign collide = ~sram_ena & ~sram_enb & (sram_addra == sram_addrb);

    // Read-return pipeline: valid/tag one cycle after grant, plus forward capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_reg   <= 1'b0;
            rd_tag_reg   <= 1'b0;
            fwd_reg      <= 1'b0;
            fwd_data_reg <= '0;
        end else begin
            rd_vld_reg <= ~sram_ena;
            if (!sram_ena) begin
                rd_tag_reg <= rd_sel;
            end
            fwd_reg <= FWD_EN & collide;
            if (collide) begin
                fwd_data_reg <= sram_dinb;
            end
        end
    end

    assign bus.rd_vld  = rd_vld_reg;
    assign bus.rd_tag  = rd_tag_reg;
    assign bus.rd_data = fwd_reg ? fwd_data_reg : sram_douta;

endmodule

// File: doc/ldpc_sram_arbiter.md
Name: ldpc_sram_arbiter

Overview:
- Shares one 256x8 two-port message SRAM between two writers and two readers inside the LDPC decoder.
- Typical writers: channel-LLR loader (W0) and check-node writeback (W1). Typical readers: variable-node update (R0) and output hard-decision unit (R1).
- Port B (write) and port A (read) are arbitrated independently with round-robin fairness.
- Adds the one-cycle read return path, requester tagging and same-address write-to-read forwarding.

Parameters:
- AW, 8, SRAM address width.
- DW, 8, SRAM data width.
- FWD_EN, 1, 1 = forward same-cycle write data to a colliding read; 0 = return old SRAM contents.

Ports:
- CLK  input  1  single system clock; also drives SRAM CLKA and CLKB.
- RST_N  input  1  asynchronous active-low reset.
- W0_REQ / W1_REQ  input  1  write request, held until granted.
- W0_ADDR / W1_ADDR  input  AW  write address.
- W0_DATA / W1_DATA  input  DW  write data.
- W0_GNT / W1_GNT  output  1  write accepted this cycle (combinational).
- R0_REQ / R1_REQ  input  1  read request, held until granted.
- R0_ADDR / R1_ADDR  input  AW  read address.
- R0_GNT / R1_GNT  output  1  read accepted this cycle (combinational).
- RD_VLD  output  1  RD_DATA valid (registered).
- RD_TAG  output  1  0 = data for R0, 1 = data for R1.
- RD_DATA  output  DW  read return data.
- SRAM_ADDRA  output  AW  to SRAM ADDRA.
- SRAM_ENA  output  1  to SRAM ENA, active low.
- SRAM_DOUTA  input  DW  from SRAM DOUTA.
- SRAM_ADDRB  output  AW  to SRAM ADDRB.
- SRAM_DINB  output  DW  to SRAM DINB.
- SRAM_ENB  output  1  to SRAM ENB, active low.
- SRAM_WEB  output  1  to SRAM WEB, active high.

Behaviour:
- Reset (async, RST_N low): RD_VLD=0, RD_TAG=0, write pointer WPTR=0, read pointer RPTR=0, forward flag cleared.
- While RST_N is low, outputs are held regardless of REQ: all GNT=0, SRAM_ENA=1, SRAM_ENB=1, SRAM_WEB=0, SRAM_ADDRA/ADDRB/DINB=0.
- Handshake: a requester holds REQ, ADDR and DATA stable until it sees GNT=1 at a rising edge. The access issues in that same cycle. REQ may drop the cycle after GNT or stay high for back-to-back accesses.
- Write arbitration, per cycle:
  - Only one of W0/W1 requesting: that one is granted.
  - Both requesting: grant index WPTR.
  - After any write grant, WPTR <= complement of the granted index.
  - No requests: WPTR unchanged.
- Read arbitration: identical scheme with RPTR.
- Fairness bound: with both requesting continuously, grants strictly alternate, so the max wait is 1 cycle.
- Write issue:
  - Granted write: SRAM_ENB=0, SRAM_WEB=1, SRAM_ADDRB/SRAM_DINB = granted ADDR/DATA. SRAM updates at the same rising edge.
  - No write: SRAM_ENB=1, SRAM_WEB=0.
- Read issue:
  - Granted read: SRAM_ENA=0, SRAM_ADDRA = granted ADDR.
  - Next cycle: RD_VLD=1, RD_TAG = granted index, RD_DATA = SRAM_DOUTA. Latency is exactly 1 cycle from GNT to RD_VLD.
  - No read grant: RD_VLD=0 next cycle. RD_DATA is don't-care when RD_VLD=0 but follows DOUTA.
- Collision (read and write granted in the same cycle to the same address):
  - The SRAM returns old data.
  - FWD_EN=1: register the write data and a forward flag; next cycle RD_DATA = registered write data.
  - FWD_EN=0: RD_DATA = SRAM_DOUTA (old data).
  - Different addresses: no interaction.
- Reads and writes never block each other. Both ports may be granted every cycle.
- Reset asserted mid-operation: a pending RD_VLD is dropped and the forward flag is cleared. Requesters must re-issue after reset.
- All pointers and flags are 1 bit. No address arithmetic, no wrap-around. Addresses pass through unmodified.

Decomposition:
- Shared package ldpc_mem_pkg:
  - Constants MSG_AW=8, MSG_DW=8.
  - Requester index encodings for writers and readers, as localparams.
- One sub-module: ldpc_rr_arb2, a 2-requester round-robin arbiter (req[1:0] -> gnt[1:0], internal pointer, async active-low reset).
  - Instantiated twice: write side and read side.
- Forwarding compare and return register live in the top module.

Test Plan:
- Reset: hold RST_N=0 with all REQ=1 -> all GNT=0, SRAM_ENA=1, SRAM_ENB=1, SRAM_WEB=0, RD_VLD=0.
- Single write/read: W0 writes 0x5A to 0x10; next cycle R1 reads 0x10 -> R1_GNT=1; next cycle RD_VLD=1, RD_TAG=1, RD_DATA=0x5A.
- Write fairness: W0 and W1 both held high for 6 cycles after reset -> grant order W0,W1,W0,W1,W0,W1; memory holds the last data of each.
- Read fairness/tags: R0 reads addr 0x01 and R1 reads addr 0x02 (preloaded 0x11, 0x22) continuously -> RD_TAG alternates 0,1,0,1 with RD_DATA 0x11,0x22 accordingly.
- Collision: addr 0x30 holds 0x00; same cycle W1 writes 0xC3 to 0x30 and R0 reads 0x30 -> FWD_EN=1: RD_DATA=0xC3; FWD_EN=0: RD_DATA=0x00; a subsequent read returns 0xC3 in both cases.
- Reset mid-read: assert RST_N low in the cycle after R0_GNT -> RD_VLD is 0 immediately; after release, WPTR/RPTR favour index 0.
